// File: rtl/cpu_param.sv
// cpu_param: parametrised multicycle CPU core with registered bus outputs,
// configurable RAM wait states and a hold/busy bus-borrow handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_FETCH  | drive IP onto the bus and post-increment, or stall on hold
// S_FWAIT  | wait RAM_WAIT cycles for instruction data
// S_DECODE | latch instruction word from data_in
// S_EXEC   | ALU/branch write-back, ST strobe, or LD address phase
// S_MWAIT  | wait RAM_WAIT cycles for load data
// S_MEM    | write load data into rd
// S_HALTED | terminal until reset, bus frozen
module cpu_param #(
    parameter int                DATA_W       = 16,
    parameter int                RAM_WAIT     = 0,
    parameter logic [DATA_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    output logic              busy,
    output logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              write
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_EXEC,
        S_MWAIT,
        S_MEM,
        S_HALTED
    } state_t;

    localparam logic [1:0] WAIT_LOAD = (RAM_WAIT > 0) ? 2'(RAM_WAIT - 1) : 2'd0;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_CMP  = 4'hA;
    localparam logic [3:0] OP_BR   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] regs [0:7];
    logic [15:0]       ir;
    logic              flag_z;
    logic              flag_c;
    logic              flag_n;
    logic [1:0]        wait_cnt;

    logic [3:0]        op;
    logic [2:0]        rd_sel;
    logic [2:0]        rs_sel;
    logic [8:0]        imm9;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] br_target;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_we;
    logic              flags_we;
    logic              br_taken;

    assign op        = ir[15:12];
    assign rd_sel    = ir[11:9];
    assign rs_sel    = ir[8:6];
    assign imm9      = ir[8:0];
    assign rd_val    = regs[rd_sel];
    assign rs_val    = regs[rs_sel];
    assign sum_ext   = {1'b0, rd_val} + {1'b0, rs_val};
    assign diff      = rd_val - rs_val;
    assign br_target = regs[7] + {{(DATA_W-9){imm9[8]}}, imm9};

    // ALU result, carry and write-enables for the instruction in EXEC
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_we   = 1'b0;
        flags_we = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res  = sum_ext[DATA_W-1:0];
                alu_c    = sum_ext[DATA_W];
                alu_we   = 1'b1;
                flags_we = 1'b1;
            end
            OP_SUB: begin
                alu_res  = diff;
                alu_c    = (rd_val < rs_val);
                alu_we   = 1'b1;
                flags_we = 1'b1;
            end
            OP_AND: begin
                alu_res  = rd_val & rs_val;
                alu_we   = 1'b1;
                flags_we = 1'b1;
            end
            OP_OR: begin
                alu_res  = rd_val | rs_val;
                alu_we   = 1'b1;
                flags_we = 1'b1;
            end
            OP_XOR: begin
                alu_res  = rd_val ^ rs_val;
                alu_we   = 1'b1;
                flags_we = 1'b1;
            end
            OP_MOV: begin
                alu_res = rs_val;
                alu_we  = 1'b1;
            end
            OP_LDI: begin
                alu_res = {{(DATA_W-9){1'b0}}, imm9};
                alu_we  = 1'b1;
            end
            OP_CMP: begin
                alu_res  = diff;
                alu_c    = (rd_val < rs_val);
                flags_we = 1'b1;
            end
            default: ;
        endcase
    end

    // branch condition evaluation; rd field carries the condition code
    always_comb begin
        br_taken = 1'b0;
        case (rd_sel)
            3'd0:    br_taken = 1'b1;
            3'd1:    br_taken = flag_z;
            3'd2:    br_taken = ~flag_z;
            3'd3:    br_taken = flag_c;
            3'd4:    br_taken = ~flag_c;
            3'd5:    br_taken = flag_n;
            default: br_taken = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (!hold) begin
                    state_next = (RAM_WAIT > 0) ? S_FWAIT : S_DECODE;
                end
            end
            S_FWAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (op == OP_HALT) begin
                    state_next = S_HALTED;
                end else if (op == OP_LD) begin
                    state_next = (RAM_WAIT > 0) ? S_MWAIT : S_MEM;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MWAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_next = S_MEM;
                end
            end
            S_MEM:    state_next = S_FETCH;
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_FETCH;
        endcase
    end

    // datapath: register file, flags, wait counter and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                regs[i] <= '0;
            end
            regs[7]  <= RESET_VECTOR;
            ir       <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_n   <= 1'b0;
            wait_cnt <= 2'd0;
            address  <= '0;
            data_out <= '0;
            write    <= 1'b0;
            busy     <= 1'b1;
        end else begin
            write <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (hold) begin
                        busy <= 1'b1;
                    end else begin
                        busy     <= 1'b0;
                        address  <= regs[7];
                        regs[7]  <= regs[7] + DATA_W'(1);
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                S_FWAIT, S_MWAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_DECODE: ir <= data_in[15:0];
                S_EXEC: begin
                    if (alu_we) begin
                        regs[rd_sel] <= alu_res;
                    end
                    if (flags_we) begin
                        flag_z <= (alu_res == '0);
                        flag_c <= alu_c;
                        flag_n <= alu_res[DATA_W-1];
                    end
                    if (op == OP_BR && br_taken) begin
                        regs[7] <= br_target;
                    end
                    if (op == OP_ST) begin
                        address  <= rs_val;
                        data_out <= rd_val;
                        write    <= 1'b1;
                    end
                    if (op == OP_LD) begin
                        address  <= rs_val;
                        wait_cnt <= WAIT_LOAD;
                    end
                    if (op == OP_HALT) begin
                        busy <= 1'b1;
                    end
                end
                S_MEM:    regs[rd_sel] <= data_in;
                S_HALTED: busy <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cpu_param.md
# cpu_param

Parametrised multicycle CPU core: the next-generation replacement for the fixed 16-bit core. It has a configurable data/address width, a configurable RAM wait-state count and a reset vector. Over the previous core it adds load/store through registers, compare, conditional branches, HALT, and a hold/busy bus handshake. It sits between the shared RAM/peripheral bus and the game logic, which uses `hold` to borrow the bus.

## Interface
Parameters:
- DATA_W, 16, register, data and address width (≥16; instruction encoding uses bits [15:0], upper bits ignored)
- RAM_WAIT, 0, extra cycles (0–3) between driving `address` and `data_in` being valid
- RESET_VECTOR, 0, IP value loaded at reset

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  bus request from other master; honoured only at instruction boundary
- busy  out  1  1 = core not executing (reset, held, halted)
- address  out  DATA_W  bus address
- data_in  in  DATA_W  read data
- data_out  out  DATA_W  write data
- write  out  1  one-cycle write strobe

## Operation
- Registers R0–R7 are DATA_W wide. R6 = SP (plain register, no auto behaviour). R7 = IP. Writing R7 via MOV/LDI/LD is a jump.
- Flags: Z (result==0), C (carry out of ADD; borrow of SUB/CMP, i.e. rd<rs unsigned), N (result MSB). Only ADD/SUB/AND/OR/XOR/CMP update the flags; AND/OR/XOR clear C.
- Encoding: [15:12] op, [11:9] rd/cond, [8:6] rs, [8:0] imm9.
  - 0 NOP
  - 1 ADD rd+=rs
  - 2 SUB rd-=rs
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 MOV rd=rs
  - 7 LDI rd=zext(imm9)
  - 8 LD rd=mem[rs]
  - 9 ST mem[rs]=rd
  - A CMP (SUB, flags only)
  - B BR cond: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6/7 never. Taken branch sets IP += sext(imm9), using IP already incremented.
  - C–E NOP
  - F HALT
- Arithmetic wraps mod 2^DATA_W. IP wraps from all-ones to 0.
- States and transitions:
  - FETCH: if hold, stay, busy=1, write=0, address unchanged. Else busy=0, address=IP, IP+=1, go to FWAIT if RAM_WAIT>0, else DECODE.
  - FWAIT: count RAM_WAIT cycles, then go to DECODE.
  - DECODE: latch data_in as instruction, then go to EXEC.
  - EXEC:
    - ALU/MOV/LDI/CMP/BR: write back, go to FETCH.
    - ST: address=rs, data_out=rd, write=1, go to FETCH.
    - LD: address=rs, go to MWAIT if RAM_WAIT>0, else MEM.
    - HALT: go to HALTED.
  - MWAIT: count RAM_WAIT cycles, then go to MEM.
  - MEM: rd=data_in, go to FETCH.
  - HALTED: busy=1, terminal until reset. `hold` is ignored.
- write is asserted only in the cycle after the EXEC of ST and is forced to 0 in every other state.
- Reset (at any time, including mid-instruction or mid-write): state=FETCH, IP=RESET_VECTOR, R0–R6=0, flags=0, busy=1, address=0, data_out=0, write=0. Any in-flight instruction is abandoned with no register or memory effect.

## Timing
- W = RAM_WAIT. Instruction latency:
  - ALU/MOV/LDI/CMP/BR/NOP/ST: 3+W cycles
  - LD: 4+2W cycles
- First fetch address appears the cycle after reset deasserts.
- hold rises during an instruction: the instruction completes, then the core stalls in FETCH. Fetch resumes the cycle after hold falls.
- busy changes in the same cycle as the state register; it is registered, never combinational.
- hold is still sampled while a ST write strobe is out; the write strobe is never cancelled by hold.
- LD into R7 takes effect at the next FETCH, with no extra increment.

## Test plan
- W=0, reset vector 0x0000, program LDI R0,5; LDI R1,3; SUB R0,R1 -> R0=2, Z=0, C=0, each instruction completes in 3 cycles.
- CMP R1,R0 with R1=3, R0=5, then BR cond=3 with offset −2 at IP 0x0010 -> C=1, next fetch address 0x000F.
- W=2: ST R2→[R3] with R2=0xBEEF, R3=0x0040, then LD R4,[R3] -> write pulses exactly one cycle with address 0x0040 and data 0xBEEF; R4=0xBEEF; LD takes 8 cycles.
- hold asserted mid-ADD for 5 cycles -> ADD result written; busy=1 for 5 cycles; no address change; fetch resumes the cycle after hold drops.
- Reset asserted in ST EXEC, and ADD 0xFFFF+1 -> write=0 next cycle, IP=RESET_VECTOR; ADD result 0, Z=1, C=1.
- HALT then hold toggles -> busy stays 1, address and write frozen until reset.
